// File: rtl/hdmi_cfg_pkg.sv
// Shared types for the HDMI transmitter configuration sequencer.
package hdmi_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        ADVANCE = 2'd3
    } seq_state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/step_edge_sync.sv
// Brings the asynchronous step button into the clk domain and turns each
// rising edge into a single-cycle pulse, registered on the third clk edge
// after the input rises.
module step_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic step_async,
    output logic step_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;
    logic pulse_q, pulse_d;

    // Two synchroniser stages, a history stage and the registered edge pulse.
    always_comb begin
        sync1_d = step_async;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        pulse_d = sync2_q & ~sync3_q;
    end

    // State update; reset clears the whole chain so no spurious edge appears.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            pulse_q <= pulse_d;
        end
    end

    assign step_pulse = pulse_q;

endmodule

// File: rtl/cfg_rom_sequencer.sv
// Walks an external configuration ROM and hands each word to the I2C config
// master over a valid/ready handshake. Manual mode advances one entry per
// step press; auto mode streams the table after a start pulse.
// Optional feature macro: CFG_ROM_SEQ_END_MARKER_EN -- when defined, a ROM
// word equal to END_WORD terminates the table instead of being presented.
module cfg_rom_sequencer
    import hdmi_cfg_pkg::*;
#(
    parameter int unsigned         DATA_W      = 16,
    parameter int unsigned         ADDR_W      = 5,
    parameter int unsigned         DEPTH       = 32,
    parameter int unsigned         ROM_LATENCY = 1,
    parameter bit                  WRAP        = 1'b0,
    parameter logic [DATA_W-1:0]   END_WORD    = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              step,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_index,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int unsigned       LAT_W     = $clog2(ROM_LATENCY + 1);
    localparam logic [LAT_W-1:0]  LAT_MAX   = LAT_W'(ROM_LATENCY);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef CFG_ROM_SEQ_END_MARKER_EN
    localparam bit END_MARKER_EN = 1'b1;
`else
    localparam bit END_MARKER_EN = 1'b0;
`endif

    seq_state_t        state_q,     state_d;
    logic [ADDR_W-1:0] rom_addr_q,  rom_addr_d;
    logic [DATA_W-1:0] cmd_data_q,  cmd_data_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [ADDR_W-1:0] cmd_index_q, cmd_index_d;
    logic              done_q,      done_d;
    logic              overrun_q,   overrun_d;
    logic [LAT_W-1:0]  lat_cnt_q,   lat_cnt_d;
    logic              run_mode_q,  run_mode_d;

    logic step_pulse;

    step_edge_sync u_step_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .step_async (step),
        .step_pulse (step_pulse)
    );

    // Next-state logic: abort overrides everything, otherwise walk the FSM.
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = cmd_valid_q;
        cmd_index_d = cmd_index_q;
        done_d      = 1'b0;
        lat_cnt_d   = lat_cnt_q;
        run_mode_d  = run_mode_q;
        // A request arriving while a run is in progress is dropped but remembered.
        overrun_d   = overrun_q | ((state_q != IDLE) & (start | step_pulse));

        if (abort) begin
            state_d     = IDLE;
            rom_addr_d  = '0;
            cmd_valid_d = 1'b0;
            lat_cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // mode is only honoured here; it is frozen for the whole run.
                    if ((mode == MODE_AUTO && start) || (mode == MODE_MANUAL && step_pulse)) begin
                        state_d    = FETCH;
                        lat_cnt_d  = '0;
                        run_mode_d = mode;
                        overrun_d  = 1'b0;
                    end
                end
                FETCH: begin
                    // rom_q reflects rom_addr only after ROM_LATENCY clocks of hold.
                    if (lat_cnt_q == LAT_MAX) begin
                        lat_cnt_d = '0;
                        if (END_MARKER_EN && rom_q == END_WORD) begin
                            rom_addr_d = '0;
                            done_d     = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            cmd_data_d  = rom_q;
                            cmd_index_d = rom_addr_q;
                            cmd_valid_d = 1'b1;
                            state_d     = PRESENT;
                        end
                    end else begin
                        lat_cnt_d = lat_cnt_q + 1'b1;
                    end
                end
                PRESENT: begin
                    // Valid is never withdrawn before the master takes the word.
                    if (cmd_ready) begin
                        cmd_valid_d = 1'b0;
                        state_d     = ADVANCE;
                    end
                end
                ADVANCE: begin
                    lat_cnt_d = '0;
                    if (rom_addr_q == LAST_ADDR) begin
                        rom_addr_d = '0;
                        done_d     = 1'b1;
                        state_d    = (run_mode_q == MODE_AUTO && WRAP) ? FETCH : IDLE;
                    end else begin
                        rom_addr_d = rom_addr_q + 1'b1;
                        state_d    = (run_mode_q == MODE_AUTO) ? FETCH : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Register all state and outputs; reset returns to an idle, empty interface.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_index_q <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            lat_cnt_q   <= '0;
            run_mode_q  <= MODE_MANUAL;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_index_q <= cmd_index_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            lat_cnt_q   <= lat_cnt_d;
            run_mode_q  <= run_mode_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_index = cmd_index_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cfg_rom_sequencer.sv
// Directed bench for cfg_rom_sequencer: one instance with DEPTH=8, ROM_LATENCY=3,
// no wrap, and one with DEPTH=3, ROM_LATENCY=1, wrap enabled.
module tb_cfg_rom_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    int          errors = 0;
    int          checks = 0;
    logic        end_word_en = 1'b0;

    // instance A
    logic        step_a, start_a, abort_a, mode_a;
    logic [4:0]  rom_addr_a, cmd_index_a;
    logic [15:0] rom_q_a, cmd_data_a;
    logic        cmd_valid_a, cmd_ready_a, busy_a, done_a, overrun_a;
    // instance B
    logic        start_b, abort_b;
    logic [4:0]  rom_addr_b, cmd_index_b;
    logic [15:0] rom_q_b, cmd_data_b;
    logic        cmd_valid_b, cmd_ready_b, busy_b, done_b, overrun_b;

    // selection of the instance the transfer task talks to
    logic        sel;
    logic        rdy;
    assign cmd_ready_a = rdy & ~sel;
    assign cmd_ready_b = rdy & sel;

    logic        valid_s, done_s;
    logic [4:0]  index_s;
    logic [15:0] data_s;
    assign valid_s = sel ? cmd_valid_b : cmd_valid_a;
    assign done_s  = sel ? done_b      : done_a;
    assign index_s = sel ? cmd_index_b : cmd_index_a;
    assign data_s  = sel ? cmd_data_b  : cmd_data_a;

    always #10 clk = ~clk;

    cfg_rom_sequencer #(
        .DATA_W(16), .ADDR_W(5), .DEPTH(8), .ROM_LATENCY(3), .WRAP(1'b0), .END_WORD(16'hFFFF)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .step(step_a), .start(start_a), .abort(abort_a),
        .mode(mode_a), .rom_addr(rom_addr_a), .rom_q(rom_q_a), .cmd_data(cmd_data_a),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_index(cmd_index_a),
        .busy(busy_a), .done(done_a), .overrun(overrun_a)
    );

    cfg_rom_sequencer #(
        .DATA_W(16), .ADDR_W(5), .DEPTH(3), .ROM_LATENCY(1), .WRAP(1'b1), .END_WORD(16'hFFFF)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .step(1'b0), .start(start_b), .abort(abort_b),
        .mode(1'b1), .rom_addr(rom_addr_b), .rom_q(rom_q_b), .cmd_data(cmd_data_b),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_index(cmd_index_b),
        .busy(busy_b), .done(done_b), .overrun(overrun_b)
    );

    // ROM models: word = 16'h1000 + address, delivered after the configured latency
    function automatic logic [15:0] rom_word(input logic [4:0] a);
        if (end_word_en && a == 5'd2) return 16'hFFFF;
        return 16'h1000 + {11'd0, a};
    endfunction

    logic [15:0] rom_pipe_a [3];
    always @(posedge clk) begin
        rom_pipe_a[0] <= rom_word(rom_addr_a);
        rom_pipe_a[1] <= rom_pipe_a[0];
        rom_pipe_a[2] <= rom_pipe_a[1];
        rom_q_b       <= 16'h1000 + {11'd0, rom_addr_b};
    end
    assign rom_q_a = rom_pipe_a[2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // wait for a word, optionally stall, accept it, then check the done pulse
    task automatic xfer(input logic [4:0] idx, input logic exp_done, input int stall);
        logic [15:0] exp_data;
        exp_data = 16'h1000 + {11'd0, idx};
        for (int n = 0; n < 40 && !valid_s; n++) tick();
        chk("cmd_valid_arrives", valid_s, 1'b1);
        chk("cmd_index", index_s, idx);
        chk("cmd_data", data_s, exp_data);
        for (int s = 0; s < stall; s++) begin
            rdy = 1'b0;
            tick();
            chk("stall_valid_held", valid_s, 1'b1);
            chk("stall_data_stable", data_s, exp_data);
        end
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("valid_drops_after_accept", valid_s, 1'b0);
        tick();
        chk("done_after_accept", done_s, exp_done);
        $display("xfer dut=%0s idx=%0d data=%h done=%0b", sel ? "B" : "A", idx, exp_data, done_s);
    endtask

    task automatic step_press;
        step_a = 1'b1;
        tick();
        tick();
        step_a = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        step_a = 1'b0; start_a = 1'b0; abort_a = 1'b0; mode_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        sel = 1'b0; rdy = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_rom_addr", rom_addr_a, 5'd0);
        chk("rst_cmd_data", cmd_data_a, 16'h0);
        chk("rst_cmd_valid", cmd_valid_a, 1'b0);
        chk("rst_cmd_index", cmd_index_a, 5'd0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_overrun", overrun_a, 1'b0);
        reset_n = 1'b1;
        tick();

        // manual mode: one entry per step, wraps to 0 after the last entry
        mode_a = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step_press();
            xfer(5'(k % 8), (k % 8) == 7, 0);
            chk("manual_idle", busy_a, 1'b0);
            chk("manual_next_addr", rom_addr_a, 5'((k + 1) % 8));
        end
        chk("manual_no_overrun", overrun_a, 1'b0);

        // abort in IDLE rewinds the address
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_idle_addr", rom_addr_a, 5'd0);

        // auto mode with the master stalling two cycles out of three
        mode_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("auto_busy", busy_a, 1'b1);
        for (int k = 0; k < 8; k++) xfer(5'(k), k == 7, 2);
        chk("auto_end_idle", busy_a, 1'b0);
        chk("auto_end_addr", rom_addr_a, 5'd0);

        // requests while presenting are dropped and flagged
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int n = 0; n < 40 && !cmd_valid_a; n++) tick();
        chk("ovr_present", cmd_valid_a, 1'b1);
        chk("ovr_clear_before", overrun_a, 1'b0);
        step_press();
        repeat (3) tick();
        chk("ovr_step_sets", overrun_a, 1'b1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("ovr_still_valid", cmd_valid_a, 1'b1);
        chk("ovr_same_index", cmd_index_a, 5'd0);
        chk("ovr_sticky", overrun_a, 1'b1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_valid", cmd_valid_a, 1'b0);
        chk("abort_addr", rom_addr_a, 5'd0);
        chk("abort_no_done", done_a, 1'b0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("ovr_cleared_by_start", overrun_a, 1'b0);
        chk("ovr_restart_busy", busy_a, 1'b1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        $display("overrun sequence complete busy=%0b overrun=%0b", busy_a, overrun_a);

        // ROM_LATENCY=3: first word valid on the 4th edge after entering FETCH
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        chk("lat_not_yet_valid", cmd_valid_a, 1'b0);
        tick();
        chk("lat_valid", cmd_valid_a, 1'b1);
        for (int k = 0; k < 5; k++) xfer(5'(k), 1'b0, 0);
        for (int n = 0; n < 40 && !cmd_valid_a; n++) tick();
        chk("rst_mid_index", cmd_index_a, 5'd5);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst_mid_valid", cmd_valid_a, 1'b0);
        chk("rst_mid_addr", rom_addr_a, 5'd0);
        chk("rst_mid_busy", busy_a, 1'b0);
        $display("mid-transfer reset valid=%0b addr=%0d", cmd_valid_a, rom_addr_a);

        // wrapping auto run on instance B, then abort
        sel = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 7; k++) xfer(5'(k % 3), (k % 3) == 2, (k == 1) ? 1 : 0);
        chk("wrap_still_busy", busy_b, 1'b1);
        abort_b = 1'b1;
        tick();
        abort_b = 1'b0;
        chk("wrap_abort_busy", busy_b, 1'b0);
        chk("wrap_abort_addr", rom_addr_b, 5'd0);
        chk("wrap_abort_valid", cmd_valid_b, 1'b0);
        chk("wrap_abort_overrun", overrun_b, 1'b0);
        sel = 1'b0;

`ifdef CFG_ROM_SEQ_END_MARKER_EN
        // terminator at word 2 ends the auto run early
        begin
            logic saw_valid;
            logic saw_done;
            saw_valid = 1'b0;
            saw_done = 1'b0;
            end_word_en = 1'b1;
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            xfer(5'd0, 1'b0, 0);
            xfer(5'd1, 1'b0, 0);
            for (int n = 0; n < 40 && !saw_done; n++) begin
                tick();
                if (cmd_valid_a) saw_valid = 1'b1;
                if (done_a) saw_done = 1'b1;
            end
            chk("end_done", saw_done, 1'b1);
            chk("end_not_presented", saw_valid, 1'b0);
            chk("end_addr", rom_addr_a, 5'd0);
            chk("end_idle", busy_a, 1'b0);
            end_word_en = 1'b0;
            $display("end marker run done=%0b addr=%0d", saw_done, rom_addr_a);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
